coef_host_loader: RTL and testbench

Host-side initiator for the read/write port of the 8-bank coefficient RAM (addrLrw/addrRrw, datainLrw/datainRrw, weL/weR, dataoutLrw/dataoutRrw).
- Accepts a byte-wide command stream from the host link (valid/ready).
- Assembles 36-bit coefficients and issues single-cycle RAM writes with auto-incrementing address.
- Performs readback, returning coefficients as a byte stream (valid/ready).
- Sits between the host byte interface and the coefficient RAM; the filter datapath keeps its own read ports.

---
 rtl/coef_loader_pkg.sv | 26 ++
 rtl/coef_byte_serializer.sv | 63 ++++++
 rtl/coef_host_loader.sv | 184 ++++++++++++++++++
 tb/tb_coef_host_loader.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/coef_loader_pkg.sv
// Shared constants, opcodes and FSM state encoding for the
// host-side coefficient RAM loader.
package coef_loader_pkg;

   localparam int ADDR_W      = 14;
   localparam int DATA_W      = 36;
   localparam int RD_LAT      = 1;
   localparam int NBYTES_WORD = 5;

   localparam logic [7:0] CMD_SET_ADDR = 8'h01;
   localparam logic [7:0] CMD_WR_L     = 8'h02;
   localparam logic [7:0] CMD_WR_R     = 8'h03;
   localparam logic [7:0] CMD_RD_L     = 8'h04;
   localparam logic [7:0] CMD_RD_R     = 8'h05;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ADDR_HI,
      S_ADDR_LO,
      S_WDATA,
      S_WRITE,
      S_RWAIT,
      S_RDATA
   } state_e;

endpackage

// File: rtl/coef_byte_serializer.sv
// Turns one coefficient word into an MSB-first byte stream.
// Zero-extends the word to a whole number of bytes.
module coef_byte_serializer
   import coef_loader_pkg::*;
#(
   parameter int DATA_W = coef_loader_pkg::DATA_W,
   parameter int NBYTES = NBYTES_WORD
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load,
   input  logic [DATA_W-1:0] word,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic              done
);

   localparam int SW = NBYTES * 8;
   localparam logic [2:0] LAST = 3'(NBYTES - 1);

   logic [SW-1:0] sh_q, sh_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          valid_q, valid_d;

   // Load a word, then shift one byte out per handshake.
   always_comb begin
      sh_d    = sh_q;
      cnt_d   = cnt_q;
      valid_d = valid_q;
      done    = 1'b0;
      if (load) begin
         sh_d    = {{(SW-DATA_W){1'b0}}, word};
         cnt_d   = 3'd0;
         valid_d = 1'b1;
      end else if (valid_q && tx_ready) begin
         sh_d = {sh_q[SW-9:0], 8'h00};
         if (cnt_q == LAST) begin
            valid_d = 1'b0;
            done    = 1'b1;
         end else begin
            cnt_d = cnt_q + 3'd1;
         end
      end
   end

   // Shift register, byte counter and valid flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         sh_q    <= '0;
         cnt_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         sh_q    <= sh_d;
         cnt_q   <= cnt_d;
         valid_q <= valid_d;
      end
   end

   assign tx_data  = sh_q[SW-1 -: 8];
   assign tx_valid = valid_q;

endmodule

// File: rtl/coef_host_loader.sv
// Host byte-stream initiator for the coefficient RAM rw port:
// address set, word writes and word readback.
module coef_host_loader
   import coef_loader_pkg::*;
#(
   parameter int ADDR_W = coef_loader_pkg::ADDR_W,
   parameter int DATA_W = coef_loader_pkg::DATA_W,
   parameter int RD_LAT = coef_loader_pkg::RD_LAT
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic [7:0]        tx_data,
   output logic              tx_valid,
   input  logic              tx_ready,
   output logic [ADDR_W-1:0] addrLrw,
   output logic [ADDR_W-1:0] addrRrw,
   output logic [DATA_W-1:0] datainLrw,
   output logic [DATA_W-1:0] datainRrw,
   output logic              weL,
   output logic              weR,
   input  logic [DATA_W-1:0] dataoutLrw,
   input  logic [DATA_W-1:0] dataoutRrw,
   output logic              busy,
   output logic              bad_cmd
);

   localparam logic [2:0] LAST_B = 3'(NBYTES_WORD - 1);
   localparam logic [2:0] LAST_W = 3'(RD_LAT);

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   ptr_q, ptr_d;
   logic [ADDR_W-9:0]   hi_q, hi_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [2:0]          cnt_q, cnt_d;
   logic                side_q, side_d;
   logic                we_l_q, we_l_d;
   logic                we_r_q, we_r_d;
   logic                bad_q, bad_d;
   logic                ld;
   logic                ser_done;
   logic                rx_fire;

   assign rx_fire = rx_valid && rx_ready;

   // Command decode, payload assembly and pointer management.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      hi_d    = hi_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      side_d  = side_q;
      we_l_d  = 1'b0;
      we_r_d  = 1'b0;
      bad_d   = 1'b0;
      ld      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (rx_fire) begin
               cnt_d = 3'd0;
               case (rx_data)
                  CMD_SET_ADDR: state_d = S_ADDR_HI;
                  CMD_WR_L: begin
                     state_d = S_WDATA;
                     side_d  = 1'b0;
                  end
                  CMD_WR_R: begin
                     state_d = S_WDATA;
                     side_d  = 1'b1;
                  end
                  CMD_RD_L: begin
                     state_d = S_RWAIT;
                     side_d  = 1'b0;
                  end
                  CMD_RD_R: begin
                     state_d = S_RWAIT;
                     side_d  = 1'b1;
                  end
                  default: bad_d = 1'b1;
               endcase
            end
         end
         S_ADDR_HI: begin
            if (rx_fire) begin
               hi_d    = rx_data[ADDR_W-9:0];
               state_d = S_ADDR_LO;
            end
         end
         S_ADDR_LO: begin
            if (rx_fire) begin
               ptr_d   = {hi_q, rx_data};
               state_d = S_IDLE;
            end
         end
         S_WDATA: begin
            if (rx_fire) begin
               wdata_d = {wdata_q[DATA_W-9:0], rx_data};
               if (cnt_q == LAST_B) begin
                  state_d = S_WRITE;
                  we_l_d  = !side_q;
                  we_r_d  = side_q;
               end else begin
                  cnt_d = cnt_q + 3'd1;
               end
            end
         end
         S_WRITE: begin
            ptr_d   = ptr_q + ADDR_W'(1);
            state_d = S_IDLE;
         end
         S_RWAIT: begin
            // Bank mux follows the live address, so sample last.
            if (cnt_q == LAST_W) begin
               ld      = 1'b1;
               state_d = S_RDATA;
            end else begin
               cnt_d = cnt_q + 3'd1;
            end
         end
         S_RDATA: begin
            if (ser_done) begin
               ptr_d   = ptr_q + ADDR_W'(1);
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         hi_q    <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         side_q  <= 1'b0;
         we_l_q  <= 1'b0;
         we_r_q  <= 1'b0;
         bad_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         hi_q    <= hi_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         side_q  <= side_d;
         we_l_q  <= we_l_d;
         we_r_q  <= we_r_d;
         bad_q   <= bad_d;
      end
   end

   coef_byte_serializer #(
      .DATA_W (DATA_W),
      .NBYTES (NBYTES_WORD)
   ) u_ser (
      .clock    (clock),
      .reset    (reset),
      .load     (ld),
      .word     (side_q ? dataoutRrw : dataoutLrw),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .tx_ready (tx_ready),
      .done     (ser_done)
   );

   // Reset masks the handshake and strobes in the reset cycle itself.
   assign rx_ready  = !reset && (state_q inside
                      {S_IDLE, S_ADDR_HI, S_ADDR_LO, S_WDATA});
   assign weL       = we_l_q && !reset;
   assign weR       = we_r_q && !reset;
   assign addrLrw   = ptr_q;
   assign addrRrw   = ptr_q;
   assign datainLrw = wdata_q;
   assign datainRrw = wdata_q;
   assign busy      = (state_q != S_IDLE);
   assign bad_cmd   = bad_q;

endmodule

// File: tb/tb_coef_host_loader.sv
// Directed bench for coef_host_loader with a 1-cycle
// registered-read RAM model on the rw port.
module tb_coef_host_loader;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  rx_data = 8'h00;
   logic        rx_valid = 1'b0;
   logic        rx_ready;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready = 1'b0;
   logic [13:0] addrLrw, addrRrw;
   logic [35:0] datainLrw, datainRrw;
   logic        weL, weR;
   logic [35:0] dataoutLrw = '0;
   logic [35:0] dataoutRrw = '0;
   logic        busy, bad_cmd;

   int n_chk = 0;
   int n_fail = 0;

   logic [35:0] mem_l [0:16383];
   logic [35:0] mem_r [0:16383];

   int wl_cnt = 0, wr_cnt = 0, both_cnt = 0, bad_cnt = 0;
   int busy_cnt = 0, acc_cnt = 0;
   bit busy_win = 0, acc_win = 0;
   logic [13:0] wl_addr;
   logic [35:0] wl_data;
   logic [13:0] wr_addr_q[$];
   logic [35:0] wr_data_q[$];

   coef_host_loader dut (
      .clock      (clock),
      .reset      (reset),
      .rx_data    (rx_data),
      .rx_valid   (rx_valid),
      .rx_ready   (rx_ready),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .addrLrw    (addrLrw),
      .addrRrw    (addrRrw),
      .datainLrw  (datainLrw),
      .datainRrw  (datainRrw),
      .weL        (weL),
      .weR        (weR),
      .dataoutLrw (dataoutLrw),
      .dataoutRrw (dataoutRrw),
      .busy       (busy),
      .bad_cmd    (bad_cmd)
   );

   always #5 clock = ~clock;

   // RAM model: write on strobe, registered read of live address.
   always @(posedge clock) begin
      dataoutLrw <= mem_l[addrLrw];
      dataoutRrw <= mem_r[addrRrw];
      if (weL) mem_l[addrLrw] <= datainLrw;
      if (weR) mem_r[addrRrw] <= datainRrw;
   end

   // Mid-cycle observer of strobes and handshakes.
   always @(negedge clock) begin
      if (weL) begin
         wl_cnt++;
         wl_addr = addrLrw;
         wl_data = datainLrw;
      end
      if (weR) begin
         wr_cnt++;
         wr_addr_q.push_back(addrRrw);
         wr_data_q.push_back(datainRrw);
      end
      if (weL && weR) both_cnt++;
      if (bad_cmd) bad_cnt++;
      if (busy_win && busy) busy_cnt++;
      if (acc_win && rx_valid && rx_ready) acc_cnt++;
   end

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      @(negedge clock);
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!rx_ready) check("rx_timeout", 0, 1);
      @(posedge clock);
      #1 rx_valid = 1'b0;
   endtask

   task automatic recv_byte(input int stall, output logic [7:0] b);
      int n = 0;
      @(negedge clock);
      while (!tx_valid && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!tx_valid) check("tx_timeout", 0, 1);
      b = tx_data;
      repeat (stall) begin
         @(negedge clock);
         check("tx_hold", {tx_valid, tx_data}, {1'b1, b});
      end
      tx_ready = 1'b1;
      @(posedge clock);
      #1 tx_ready = 1'b0;
   endtask

   task automatic set_addr(input logic [7:0] hi, input logic [7:0] lo);
      send_byte(8'h01);
      send_byte(hi);
      send_byte(lo);
   endtask

   task automatic wr5(input logic [7:0] op, input logic [7:0] b0,
                      input logic [7:0] b1, input logic [7:0] b2,
                      input logic [7:0] b3, input logic [7:0] b4);
      send_byte(op);
      send_byte(b0);
      send_byte(b1);
      send_byte(b2);
      send_byte(b3);
      send_byte(b4);
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] b;
      logic [7:0] exp4 [5];
      logic [7:0] exp7 [5];
      int base_l, base_r, base_bad;

      // Reset state
      cycles(3);
      check("rst_rx_ready", rx_ready, 0);
      check("rst_tx_valid", tx_valid, 0);
      check("rst_tx_data", tx_data, 8'h00);
      check("rst_we", {weL, weR}, 2'b00);
      check("rst_addr", {addrLrw, addrRrw}, 28'h0);
      check("rst_datain", {datainLrw, datainRrw}, 72'h0);
      check("rst_busy_bad", {busy, bad_cmd}, 2'b00);
      reset = 1'b0;
      cycles(1);
      check("idle_rx_ready", rx_ready, 1);

      // SET_ADDR 0x1234, WR_L 0xABCDEF012
      set_addr(8'h12, 8'h34);
      check("setaddr", addrLrw, 14'h1234);
      wr5(8'h02, 8'h0A, 8'hBC, 8'hDE, 8'hF0, 8'h12);
      cycles(3);
      check("wl_cnt1", wl_cnt, 1);
      check("wl_addr1", wl_addr, 14'h1234);
      check("wl_data1", wl_data, 36'hABCDEF012);
      check("wr_none", wr_cnt, 0);
      check("ptr_inc", {addrLrw, addrRrw}, {14'h1235, 14'h1235});
      check("mem_l_1234", mem_l[14'h1234], 36'hABCDEF012);

      // Wrap: WR_R at 0x3FFF then 0x0000
      set_addr(8'hFF, 8'hFF);
      check("setaddr_mask", addrLrw, 14'h3FFF);
      wr5(8'h03, 8'h09, 8'h87, 8'h65, 8'h43, 8'h21);
      wr5(8'h03, 8'hF5, 8'h11, 8'h22, 8'h33, 8'h44);
      cycles(3);
      check("wr_cnt2", wr_cnt, 2);
      check("wl_unchanged", wl_cnt, 1);
      if (wr_cnt == 2) begin
         check("wr_addr_a", wr_addr_q[0], 14'h3FFF);
         check("wr_addr_b", wr_addr_q[1], 14'h0000);
         check("wr_data_b", wr_data_q[1], 36'h511223344);
      end
      check("mem_r_3fff", mem_r[14'h3FFF], 36'h987654321);
      check("ptr_wrap", addrRrw, 14'h0001);

      // Write 0x123456789 at 5, read back with stall on byte 2
      set_addr(8'h00, 8'h05);
      wr5(8'h02, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89);
      set_addr(8'h00, 8'h05);
      send_byte(8'h04);
      exp4[0] = 8'h01; exp4[1] = 8'h23; exp4[2] = 8'h45;
      exp4[3] = 8'h67; exp4[4] = 8'h89;
      for (int i = 0; i < 5; i++) begin
         recv_byte((i == 2) ? 3 : 0, b);
         check($sformatf("rdl_b%0d", i), b, exp4[i]);
      end
      cycles(2);
      check("rd_tx_idle", tx_valid, 0);
      check("rd_ptr", addrLrw, 14'h0006);

      // Unknown command byte
      base_l = wl_cnt;
      base_r = wr_cnt;
      busy_win = 1;
      send_byte(8'h7E);
      cycles(3);
      busy_win = 0;
      check("bad_pulse", bad_cnt, 1);
      check("bad_busy", busy_cnt, 0);
      check("bad_no_we", wl_cnt + wr_cnt, base_l + base_r);
      set_addr(8'h00, 8'h10);
      check("after_bad", addrLrw, 14'h0010);

      // Reset in the middle of a WR_L payload
      base_l = wl_cnt;
      send_byte(8'h02);
      send_byte(8'h11);
      send_byte(8'h22);
      send_byte(8'h33);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("mr_rx_ready", rx_ready, 0);
      check("mr_outs", {weL, weR, busy, bad_cmd, tx_valid}, 5'b0);
      check("mr_addr", addrLrw, 14'h0);
      check("mr_datain", datainLrw, 36'h0);
      check("mr_tx_data", tx_data, 8'h00);
      reset = 1'b0;
      cycles(4);
      check("mr_no_we", wl_cnt, base_l);
      wr5(8'h02, 8'h07, 8'h65, 8'h43, 8'h21, 8'h0F);
      cycles(3);
      check("mr_wl_cnt", wl_cnt, base_l + 1);
      check("mr_wl_addr", wl_addr, 14'h0000);
      check("mr_mem_l0", mem_l[14'h0000], 36'h76543210F);

      // RD_R at 0x3FFF with rx_valid held high
      base_bad = bad_cnt;
      set_addr(8'h3F, 8'hFF);
      send_byte(8'h05);
      rx_data  = 8'h7E;
      rx_valid = 1'b1;
      acc_win  = 1;
      exp7[0] = 8'h09; exp7[1] = 8'h87; exp7[2] = 8'h65;
      exp7[3] = 8'h43; exp7[4] = 8'h21;
      for (int i = 0; i < 5; i++) begin
         recv_byte(0, b);
         check($sformatf("rdr_b%0d", i), b, exp7[i]);
      end
      rx_valid = 1'b0;
      acc_win  = 0;
      cycles(2);
      check("rdr_no_accept", acc_cnt, 0);
      check("rdr_no_bad", bad_cnt, base_bad);
      check("rdr_ptr_wrap", addrRrw, 14'h0000);
      check("never_both_we", both_cnt, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
